// File: rtl/polar_pkg.sv
// Shared types and saturating LLR arithmetic for the SC decoder datapath.
package polar_pkg;

    localparam int LLR_BITS = 4;
    // Width used for intermediate arithmetic so no sum or negation can overflow.
    localparam int WIDE = 16;

    typedef logic signed [LLR_BITS-1:0] llr_t;

    typedef enum logic [1:0] {
        LOAD,
        F_OUT,
        BETA,
        G_OUT
    } state_t;

    // Clamp to the symmetric range [-(2^(bits-1)-1), +(2^(bits-1)-1)].
    function automatic logic signed [WIDE-1:0] sat_llr(input logic signed [WIDE-1:0] x,
                                                       input int bits);
        logic signed [WIDE-1:0] lim;
        lim = WIDE'((32'sd1 <<< (bits - 1)) - 32'sd1);
        if (x > lim) begin
            return lim;
        end else if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

    // Magnitude with the most negative code folded onto the largest positive value.
    function automatic logic signed [WIDE-1:0] abs_sat(input logic signed [WIDE-1:0] x,
                                                       input int bits);
        logic signed [WIDE-1:0] m;
        m = (x < 0) ? -x : x;
        return sat_llr(m, bits);
    endfunction

endpackage

// File: rtl/f_node.sv
// Combinational min-sum f node: sign product times the smaller saturated magnitude.
module f_node
    import polar_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic signed [BITS-1:0] a,
    input  logic signed [BITS-1:0] b,
    output logic signed [BITS-1:0] c
);

    logic signed [WIDE-1:0] mag_a;
    logic signed [WIDE-1:0] mag_b;
    logic signed [WIDE-1:0] mag;

    always_comb begin
        mag_a = abs_sat(WIDE'(a), BITS);
        mag_b = abs_sat(WIDE'(b), BITS);
        mag   = (mag_a < mag_b) ? mag_a : mag_b;
        // Zero has a clear sign bit, so it counts as positive.
        c     = (a[BITS-1] ^ b[BITS-1]) ? BITS'(-mag) : BITS'(mag);
    end

endmodule

// File: rtl/g_node.sv
// Combinational g node: b plus or minus a depending on the partial sum, then saturated.
module g_node
    import polar_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic signed [BITS-1:0] a,
    input  logic signed [BITS-1:0] b,
    input  logic                   u,
    output logic signed [BITS-1:0] c
);

    logic signed [WIDE-1:0] sum;

    always_comb begin
        sum = u ? (WIDE'(b) - WIDE'(a)) : (WIDE'(b) + WIDE'(a));
        c   = BITS'(sat_llr(sum, BITS));
    end

endmodule

// File: rtl/sc_llr_stage.sv
// SC decoder node stage: buffers one alpha vector, streams f results, collects
// the left child's partial sums, then streams g results.
module sc_llr_stage
    import polar_pkg::*;
#(
    parameter int BITS = 4,
    parameter int N    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BITS-1:0] in_llr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BITS-1:0] out_llr,
    output logic                   out_is_g,
    input  logic                   beta_valid,
    output logic                   beta_ready,
    input  logic                   beta_bit,
    output logic                   busy
);

    localparam int IW   = $clog2(N);
    localparam int HALF = N / 2;
    localparam logic [IW-1:0] IDX_LAST      = IW'(N - 1);
    localparam logic [IW-1:0] IDX_HALF_LAST = IW'(HALF - 1);
    localparam logic [IW-1:0] IDX_HALF      = IW'(HALF);

    state_t                 state_reg;
    state_t                 state_next;
    logic [IW-1:0]          idx_reg;
    logic [IW-1:0]          idx_next;
    logic signed [BITS-1:0] alpha_mem [N];
    logic [HALF-1:0]        beta_reg;

    logic                   in_fire;
    logic                   out_fire;
    logic                   beta_fire;
    logic signed [BITS-1:0] a_sel;
    logic signed [BITS-1:0] b_sel;
    logic                   u_sel;
    logic signed [BITS-1:0] f_res;
    logic signed [BITS-1:0] g_res;

    // Handshake outputs depend only on state, and are forced low while reset is held.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        beta_ready = 1'b0;
        out_is_g   = 1'b0;
        busy       = 1'b0;
        if (!rst) begin
            case (state_reg)
                LOAD:  in_ready = 1'b1;
                F_OUT: begin
                    out_valid = 1'b1;
                    busy      = 1'b1;
                end
                BETA:  begin
                    beta_ready = 1'b1;
                    busy       = 1'b1;
                end
                G_OUT: begin
                    out_valid = 1'b1;
                    out_is_g  = 1'b1;
                    busy      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign beta_fire = beta_valid & beta_ready;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            LOAD: begin
                if (in_fire) begin
                    if (idx_reg == IDX_LAST) begin
                        state_next = F_OUT;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            F_OUT: begin
                if (out_fire) begin
                    if (idx_reg == IDX_HALF_LAST) begin
                        state_next = BETA;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            BETA: begin
                if (beta_fire) begin
                    if (idx_reg == IDX_HALF_LAST) begin
                        state_next = G_OUT;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            G_OUT: begin
                if (out_fire) begin
                    if (idx_reg == IDX_HALF_LAST) begin
                        state_next = LOAD;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = LOAD;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Frame buffers carry no reset; a new frame always overwrites every entry before use.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            alpha_mem[idx_reg] <= in_llr;
        end
        for (int i = 0; i < HALF; i++) begin
            if (beta_fire && idx_reg == IW'(i)) begin
                beta_reg[i] <= beta_bit;
            end
        end
    end

    always_comb begin
        a_sel = alpha_mem[idx_reg];
        b_sel = alpha_mem[idx_reg + IDX_HALF];
        u_sel = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            if (idx_reg == IW'(i)) begin
                u_sel = beta_reg[i];
            end
        end
    end

    f_node #(
        .BITS(BITS)
    ) u_f_node (
        .a(a_sel),
        .b(b_sel),
        .c(f_res)
    );

    g_node #(
        .BITS(BITS)
    ) u_g_node (
        .a(a_sel),
        .b(b_sel),
        .u(u_sel),
        .c(g_res)
    );

    assign out_llr = !out_valid ? '0 : (out_is_g ? g_res : f_res);

endmodule
